// File: rtl/ti_sif_responder.sv
// Target-side model of the TI serial register interface: oversampled SIF decode,
// a local register file, and serial read-back on o_sif_sdout.
module ti_sif_responder #(
    parameter int P_SIF_ADDR_BITS  = 8,
    parameter int P_SIF_DATA_BITS  = 8,
    parameter int P_SIF_RD_WR_BITS = 1,
    parameter int P_REG_WORDS      = 64
) (
    input  logic                       i_sysclk,
    input  logic                       i_srst_n,
    input  logic                       i_sif_reset_n,
    input  logic                       i_sif_sclk,
    input  logic                       i_sif_sel_n,
    input  logic                       i_sif_sdin,
    output logic                       o_sif_sdout,
    output logic                       o_sif_sdout_oe,
    output logic                       o_wr_valid,
    output logic [P_SIF_ADDR_BITS-1:0] o_wr_addr,
    output logic [P_SIF_DATA_BITS-1:0] o_wr_data,
    output logic                       o_frame_err,
    input  logic [P_SIF_ADDR_BITS-1:0] i_rd_addr,
    output logic [P_SIF_DATA_BITS-1:0] o_rd_data
);

    localparam int HDR   = P_SIF_RD_WR_BITS + P_SIF_ADDR_BITS;
    localparam int N     = HDR + P_SIF_DATA_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam int TXC_W = $clog2(P_SIF_DATA_BITS + 1);
    localparam int IDX_W = (P_REG_WORDS > 1) ? $clog2(P_REG_WORDS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_OVERRUN = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    function automatic logic in_range(input logic [P_SIF_ADDR_BITS-1:0] a);
        return {1'b0, a} < (P_SIF_ADDR_BITS + 1)'(P_REG_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [P_SIF_ADDR_BITS-1:0] a);
        logic [P_SIF_ADDR_BITS+IDX_W-1:0] wide;
        wide = {{IDX_W{1'b0}}, a};
        return wide[IDX_W-1:0];
    endfunction

    // Synchroniser chains: _p0/_p1 are the 2-FF sync, _p2 is the delayed copy for edges
    logic sclk_p0, sclk_p1, sclk_p2;
    logic sel_p0, sel_p1, sel_p2;
    logic sdin_p0, sdin_p1;
    logic chip_rst_p0, chip_rst_p1;

    always_ff @(posedge i_sysclk) begin
        if (!i_srst_n) begin
            {sclk_p0, sclk_p1, sclk_p2} <= '0;
            {sel_p0, sel_p1, sel_p2}    <= '0;
            {sdin_p0, sdin_p1}          <= '0;
            {chip_rst_p0, chip_rst_p1}  <= '0;
        end else begin
            {sclk_p0, sclk_p1, sclk_p2} <= {i_sif_sclk, sclk_p0, sclk_p1};
            {sel_p0, sel_p1, sel_p2}    <= {i_sif_sel_n, sel_p0, sel_p1};
            {sdin_p0, sdin_p1}          <= {i_sif_sdin, sdin_p0};
            {chip_rst_p0, chip_rst_p1}  <= {i_sif_reset_n, chip_rst_p0};
        end
    end

    logic sclk_rise, sclk_fall, sel_rise, sel_fall, chip_rst;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign sel_rise  = sel_p1 & ~sel_p2;
    assign sel_fall  = ~sel_p1 & sel_p2;
    assign chip_rst  = ~chip_rst_p1;

    logic [1:0]                 state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [N-1:0]               shift;
    logic [N-1:0]               shift_nxt;
    logic                       rd_phase;
    logic [TXC_W-1:0]           tx_left;
    logic [P_SIF_DATA_BITS-1:0] tx;
    logic [P_SIF_DATA_BITS-1:0] regs [P_REG_WORDS];

    logic                       frame_rw, hdr_rw;
    logic [P_SIF_ADDR_BITS-1:0] frame_addr, hdr_addr;
    logic [P_SIF_DATA_BITS-1:0] frame_data;

    assign shift_nxt  = {shift[N-2:0], sdin_p1};
    assign frame_rw   = (P_SIF_RD_WR_BITS != 0) && shift[N-1];
    assign frame_addr = shift[P_SIF_DATA_BITS +: P_SIF_ADDR_BITS];
    assign frame_data = shift[P_SIF_DATA_BITS-1:0];
    // Header as it will look once the current sclk rise lands the last address bit
    assign hdr_rw     = (P_SIF_RD_WR_BITS != 0) && shift_nxt[HDR-1];
    assign hdr_addr   = shift_nxt[P_SIF_ADDR_BITS-1:0];

    always_ff @(posedge i_sysclk) begin
        if (!i_srst_n) begin
            state          <= S_IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            rd_phase       <= 1'b0;
            tx_left        <= '0;
            tx             <= '0;
            o_sif_sdout    <= 1'b0;
            o_sif_sdout_oe <= 1'b0;
            o_wr_valid     <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_frame_err    <= 1'b0;
            o_rd_data      <= '0;
            for (int i = 0; i < P_REG_WORDS; i++) regs[i] <= '0;
        end else begin
            o_wr_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_rd_data   <= in_range(i_rd_addr) ? regs[reg_idx(i_rd_addr)] : '0;

            if (chip_rst) begin
                state          <= S_IDLE;
                bit_cnt        <= '0;
                shift          <= '0;
                rd_phase       <= 1'b0;
                tx_left        <= '0;
                o_sif_sdout    <= 1'b0;
                o_sif_sdout_oe <= 1'b0;
                for (int i = 0; i < P_REG_WORDS; i++) regs[i] <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sel_fall) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                            shift   <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (sel_rise) begin
                            rd_phase       <= 1'b0;
                            tx_left        <= '0;
                            o_sif_sdout    <= 1'b0;
                            o_sif_sdout_oe <= 1'b0;
                            if (bit_cnt == CNT_W'(N)) begin
                                state <= S_COMMIT;
                            end else begin
                                state       <= S_IDLE;
                                o_frame_err <= 1'b1;
                            end
                        end else if (sclk_rise) begin
                            if (bit_cnt == CNT_W'(N)) begin
                                state          <= S_OVERRUN;
                                rd_phase       <= 1'b0;
                                o_sif_sdout    <= 1'b0;
                                o_sif_sdout_oe <= 1'b0;
                            end else begin
                                shift   <= shift_nxt;
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == CNT_W'(HDR - 1) && hdr_rw) begin
                                    rd_phase <= 1'b1;
                                    tx_left  <= TXC_W'(P_SIF_DATA_BITS);
                                    tx       <= in_range(hdr_addr) ? regs[reg_idx(hdr_addr)] : '0;
                                end
                            end
                        end else if (sclk_fall && rd_phase) begin
                            if (tx_left != '0) begin
                                o_sif_sdout    <= tx[P_SIF_DATA_BITS-1];
                                o_sif_sdout_oe <= 1'b1;
                                tx             <= tx << 1;
                                tx_left        <= tx_left - 1'b1;
                            end else begin
                                rd_phase       <= 1'b0;
                                o_sif_sdout    <= 1'b0;
                                o_sif_sdout_oe <= 1'b0;
                            end
                        end
                    end
                    S_OVERRUN: begin
                        if (sel_rise) begin
                            state       <= S_IDLE;
                            o_frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        // Commit: reads have no side effects, unimplemented addresses are dropped
                        if (!frame_rw && in_range(frame_addr)) begin
                            regs[reg_idx(frame_addr)] <= frame_data;
                            o_wr_valid <= 1'b1;
                            o_wr_addr  <= frame_addr;
                            o_wr_data  <= frame_data;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ti_sif_responder.sv
// Randomized bench for ti_sif_responder: a bit-banging SIF master plus a
// frame-level register model that predicts writes, errors and read-back data.
module tb_ti_sif_responder;

    logic       clk = 1'b0;
    logic       srst_n = 1'b0;
    logic       sif_reset_n = 1'b1;
    logic       sif_sclk = 1'b0;
    logic       sif_sel_n = 1'b1;
    logic       sif_sdin = 1'b0;
    logic       sdout, sdout_oe, wr_valid, frame_err;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    int         wr_cnt = 0, err_cnt = 0;
    logic [7:0] last_wr_addr, last_wr_data;
    logic [7:0] rd_at_commit, rd_after_commit;
    bit         grab_next = 1'b0;
    logic [7:0] model_mem [64];

    always #5 clk = ~clk;

    ti_sif_responder dut (
        .i_sysclk       (clk),
        .i_srst_n       (srst_n),
        .i_sif_reset_n  (sif_reset_n),
        .i_sif_sclk     (sif_sclk),
        .i_sif_sel_n    (sif_sel_n),
        .i_sif_sdin     (sif_sdin),
        .o_sif_sdout    (sdout),
        .o_sif_sdout_oe (sdout_oe),
        .o_wr_valid     (wr_valid),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_frame_err    (frame_err),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data)
    );

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
            rd_at_commit = rd_data;
            grab_next    = 1'b1;
        end else if (grab_next) begin
            rd_after_commit = rd_data;
            grab_next       = 1'b0;
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return (a < 8'd64) ? model_mem[a[5:0]] : 8'h00;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    endfunction

    task automatic check_local(input logic [7:0] a);
        rd_addr = a;
        wait_cyc(2);
        check("local_rd", rd_data, model_rd(a));
    endtask

    // Master: sdin changes while sclk is low, responder samples on the rise;
    // read data is sampled at the end of each low phase.
    task automatic run_frame(input logic [31:0] bits, input int nbits, input bit rd,
                             output logic [7:0] got);
        got = 8'h00;
        sif_sel_n = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < nbits; i++) begin
            sif_sdin = bits[nbits-1-i];
            sif_sclk = 1'b0;
            wait_cyc(4);
            if (rd && i >= 9 && i < 17) begin
                got = {got[6:0], sdout};
                check("oe_data", sdout_oe, 1);
            end else if (!rd || i < 9) begin
                check("oe_idle", sdout_oe, 0);
            end
            sif_sclk = 1'b1;
            wait_cyc(4);
        end
        sif_sclk = 1'b0;
        wait_cyc(4);
        sif_sel_n = 1'b1;
        wait_cyc(8);
        check("oe_after", {sdout_oe, sdout}, 0);
    endtask

    task automatic do_frame(input logic [31:0] bits, input int nbits);
        int         wr0, er0;
        bit         is_rd;
        logic [7:0] got, a, d;
        wr0   = wr_cnt;
        er0   = err_cnt;
        is_rd = (nbits == 17) && bits[16];
        a     = bits[15:8];
        d     = bits[7:0];
        run_frame(bits, nbits, is_rd, got);
        if (nbits != 17) begin
            check("frame_err", err_cnt - er0, 1);
            check("bad_no_wr", wr_cnt - wr0, 0);
        end else begin
            check("no_err", err_cnt - er0, 0);
            if (is_rd) begin
                check("rd_serial", got, model_rd(a));
                check("rd_no_wr", wr_cnt - wr0, 0);
            end else if (a < 8'd64) begin
                check("wr_pulse", wr_cnt - wr0, 1);
                check("wr_addr", last_wr_addr, a);
                check("wr_data", last_wr_data, d);
                model_mem[a[5:0]] = d;
            end else begin
                check("oor_no_wr", wr_cnt - wr0, 0);
            end
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int nbits, input int count);
        sif_sel_n = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < count; i++) begin
            sif_sdin = bits[nbits-1-i];
            sif_sclk = 1'b0;
            wait_cyc(4);
            sif_sclk = 1'b1;
            wait_cyc(4);
        end
    endtask

    initial begin
        logic [16:0] f;
        int          wr0, er0, r;
        rd_addr = 8'h00;
        model_clear();

        wait_cyc(5);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_sdout", {sdout_oe, sdout}, 0);
        check("rst_wr_bus", {wr_addr, wr_data}, 0);
        check("rst_rd_data", rd_data, 0);
        srst_n = 1'b1;
        wait_cyc(5);

        // Write then serial read-back, with a local read racing the commit
        rd_addr = 8'h12;
        do_frame({15'd0, 1'b0, 8'h12, 8'hA5}, 17);
        check("rd_old_at_commit", rd_at_commit, 8'h00);
        check("rd_new_after", rd_after_commit, 8'hA5);
        check_local(8'h12);
        do_frame({15'd0, 1'b1, 8'h12, 8'h00}, 17);

        // Short and long frames must not touch the register
        f = {1'b0, 8'h12, 8'h3C};
        do_frame({22'd0, f[16:7]}, 10);
        do_frame({14'd0, f, 1'b0}, 18);
        check_local(8'h12);

        // Unimplemented address
        do_frame({15'd0, 1'b0, 8'h50, 8'hFF}, 17);
        do_frame({15'd0, 1'b1, 8'h50, 8'h00}, 17);

        // Chip reset mid-frame
        wr0 = wr_cnt;
        er0 = err_cnt;
        send_bits({15'd0, 1'b0, 8'h12, 8'h99}, 17, 5);
        sif_reset_n = 1'b0;
        wait_cyc(10);
        sif_reset_n = 1'b1;
        wait_cyc(6);
        sif_sclk  = 1'b0;
        sif_sel_n = 1'b1;
        wait_cyc(8);
        model_clear();
        check("chiprst_no_err", err_cnt - er0, 0);
        check("chiprst_no_wr", wr_cnt - wr0, 0);
        check_local(8'h12);
        do_frame({15'd0, 1'b0, 8'h12, 8'h77}, 17);
        check_local(8'h12);

        // System reset at bit 9 of a write frame
        send_bits({15'd0, 1'b0, 8'h21, 8'h5A}, 17, 9);
        srst_n = 1'b0;
        wait_cyc(2);
        check("srst_outputs", {wr_valid, frame_err, sdout, sdout_oe, wr_addr, wr_data, rd_data}, 0);
        sif_sclk  = 1'b0;
        sif_sel_n = 1'b1;
        wait_cyc(4);
        srst_n = 1'b1;
        wait_cyc(8);
        model_clear();
        do_frame({15'd0, 1'b0, 8'h21, 8'h5A}, 17);
        check_local(8'h21);
        check_local(8'h12);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            f = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), 8'($urandom)};
            r = $urandom_range(0, 9);
            if (r < 7) begin
                do_frame({15'd0, f}, 17);
            end else begin
                f[16] = 1'b0;
                if (r == 7)      do_frame({22'd0, f[16:7]}, 10);
                else if (r == 8) do_frame({14'd0, f, 1'b0}, 18);
                else             do_frame({27'd0, f[16:12]}, 5);
            end
            check_local(8'($urandom_range(0, 79)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
